// File: rtl/vsc_pkg.sv
// Shared definitions for the video stream checker.
//
// Contents:
//   vsc_state_e          - receiver FSM states
//   ERR_HLEN/VLEN/GAP    - bit positions inside the error flag vector
//   DEF_H_ACT/DEF_V_ACT  - default raster size, shared with the stimulus source
package vsc_pkg;

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        IDLE     = 3'd1,
        LINE_GAP = 3'd2,
        ACTIVE   = 3'd3,
        DONE     = 3'd4
    } vsc_state_e;

    localparam int ERR_HLEN = 0;
    localparam int ERR_VLEN = 1;
    localparam int ERR_GAP  = 2;
    localparam int ERR_W    = 3;

    localparam int DEF_H_ACT = 1920;
    localparam int DEF_V_ACT = 1080;

endpackage

// File: rtl/vsc_edge_det.sv
// Registered edge detector for a small vector of qualifier signals.
//
// Ports:
//   clk     - clock, posedge
//   rst_b   - synchronous active-low reset; clears the history register
//   in_i    - sampled input levels
//   rise_o  - bit high in the cycle a 0->1 transition is sampled
//   fall_o  - bit high in the cycle a 1->0 transition is sampled
module vsc_edge_det
    import vsc_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            prev_q <= '0;
        end else begin
            prev_q <= in_i;
        end
    end

    // Edges compare the current input with last cycle's level, so an edge is
    // reported in the same cycle the new level is present.
    assign rise_o = in_i & ~prev_q;
    assign fall_o = ~in_i & prev_q;

endmodule

// File: rtl/video_stream_checker.sv
// Sink-side checker for an hvalid/vvalid qualified 8-bit raster stream.
// Counts columns and rows, sums pixels, flags protocol violations and
// publishes one report per frame together with a single-cycle frame_done.
//
// Ports:
//   clk        - clock, posedge
//   rst_b      - synchronous active-low reset
//   hvalid     - line-active qualifier
//   vvalid     - frame-active qualifier
//   din        - pixel, valid when hvalid && vvalid
//   frame_done - one-cycle pulse; report outputs change in this cycle
//   frame_ok   - last frame had no error flags
//   err_hlen   - some line of the last frame was not H_ACT pixels long
//   err_vlen   - last frame did not contain V_ACT lines
//   err_gap    - hvalid seen rising outside a frame since the previous report
//   rows       - lines counted in the last frame
//   last_cols  - length of the final line of the last frame
//   checksum   - mod-2^32 sum of the last frame's pixels
module video_stream_checker
    import vsc_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int V_ACT = DEF_V_ACT,
    parameter int CW    = 12,
    parameter int RW    = 11
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          hvalid,
    input  logic          vvalid,
    input  logic [7:0]    din,
    output logic          frame_done,
    output logic          frame_ok,
    output logic          err_hlen,
    output logic          err_vlen,
    output logic          err_gap,
    output logic [RW-1:0] rows,
    output logic [CW-1:0] last_cols,
    output logic [31:0]   checksum
);

    localparam int EV = 0;  // vvalid position in the edge vectors
    localparam int EH = 1;  // hvalid position in the edge vectors

    function automatic logic [CW-1:0] col_sat_inc(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    function automatic logic [RW-1:0] row_sat_inc(input logic [RW-1:0] r);
        return (r == '1) ? r : r + RW'(1);
    endfunction

    logic [1:0] rise_w;
    logic [1:0] fall_w;
    logic       pix_vld;

    vsc_state_e state_q, state_d;

    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    lastcol_q, lastcol_d;
    logic [RW-1:0]    row_q, row_d;
    logic [31:0]      sum_q, sum_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic [ERR_W-1:0] err_out_q, err_out_d;
    logic [RW-1:0]    rows_q, rows_d;
    logic [CW-1:0]    last_cols_q, last_cols_d;
    logic [31:0]      checksum_q, checksum_d;

    logic [ERR_W-1:0] frame_errs;

    vsc_edge_det #(
        .W(2)
    ) u_edge (
        .clk    (clk),
        .rst_b  (rst_b),
        .in_i   ({hvalid, vvalid}),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    assign pix_vld = hvalid && vvalid;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        lastcol_d    = lastcol_q;
        row_d        = row_q;
        sum_d        = sum_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        err_out_d    = err_out_q;
        rows_d       = rows_q;
        last_cols_d  = last_cols_q;
        checksum_d   = checksum_q;
        frame_errs   = err_q;

        case (state_q)
            SYNC: begin
                // Only start tracking once the source is between frames, so a
                // frame already in flight at reset release is never reported.
                if (!vvalid) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (rise_w[EH] && !vvalid) begin
                    err_d[ERR_GAP] = 1'b1;
                end
                // A line already high when vvalid rises is not counted until
                // the next cycle; it will then be short and raise err_hlen.
                if (rise_w[EV]) begin
                    col_d          = '0;
                    lastcol_d      = '0;
                    row_d          = '0;
                    sum_d          = '0;
                    err_d[ERR_HLEN] = 1'b0;
                    err_d[ERR_VLEN] = 1'b0;
                    state_d        = LINE_GAP;
                end
            end

            LINE_GAP: begin
                if (pix_vld) begin
                    col_d   = CW'(1);
                    sum_d   = sum_q + 32'(din);
                    state_d = ACTIVE;
                end else if (fall_w[EV]) begin
                    state_d = DONE;
                end
            end

            ACTIVE: begin
                if (pix_vld) begin
                    col_d = col_sat_inc(col_q);
                    sum_d = sum_q + 32'(din);
                end else if (fall_w[EH] || fall_w[EV]) begin
                    // Either qualifier dropping ends the line; a joint fall
                    // closes it once and heads straight for the report.
                    row_d = row_sat_inc(row_q);
                    if (col_q != CW'(H_ACT)) begin
                        err_d[ERR_HLEN] = 1'b1;
                    end
                    lastcol_d = col_q;
                    col_d     = '0;
                    state_d   = vvalid ? LINE_GAP : DONE;
                end
            end

            DONE: begin
                frame_errs[ERR_VLEN] = (row_q != RW'(V_ACT));
                err_d[ERR_VLEN]      = frame_errs[ERR_VLEN];
                err_out_d            = frame_errs;
                frame_ok_d           = ~|frame_errs;
                rows_d               = row_q;
                last_cols_d          = lastcol_q;
                checksum_d           = sum_q;
                frame_done_d         = 1'b1;
                err_d[ERR_GAP]       = 1'b0;
                state_d              = IDLE;
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= SYNC;
            col_q        <= '0;
            lastcol_q    <= '0;
            row_q        <= '0;
            sum_q        <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_out_q    <= '0;
            rows_q       <= '0;
            last_cols_q  <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            lastcol_q    <= lastcol_d;
            row_q        <= row_d;
            sum_q        <= sum_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_out_q    <= err_out_d;
            rows_q       <= rows_d;
            last_cols_q  <= last_cols_d;
            checksum_q   <= checksum_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_hlen   = err_out_q[ERR_HLEN];
    assign err_vlen   = err_out_q[ERR_VLEN];
    assign err_gap    = err_out_q[ERR_GAP];
    assign rows       = rows_q;
    assign last_cols  = last_cols_q;
    assign checksum   = checksum_q;

endmodule
